// File: rtl/mem_bridge.sv
// Single-port RAM bridge: arbitrates instruction fetch and load/store requests
// onto a RAMHelper-style word interface, one transaction at a time.
module mem_bridge #(
  parameter logic [63:0] BASE      = 64'h8000_0000,
  parameter logic [63:0] RAM_BYTES = 64'h0800_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [63:0] if_req_addr,
  output logic        if_resp_valid,
  output logic [31:0] if_resp_inst,
  output logic        if_resp_err,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic        d_req_we,
  input  logic [63:0] d_req_addr,
  input  logic [1:0]  d_req_size,
  input  logic [63:0] d_req_wdata,
  output logic        d_resp_valid,
  output logic [63:0] d_resp_rdata,
  output logic        d_resp_err,
  output logic        ram_ren,
  output logic [63:0] ram_ridx,
  input  logic [63:0] ram_rdata,
  output logic        ram_wen,
  output logic [63:0] ram_widx,
  output logic [63:0] ram_wdata,
  output logic [63:0] ram_wmask,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_last_grant;  // 0 = fetch, 1 = data
  logic        r_side;
  logic        r_we;
  logic [1:0]  r_size;
  logic [2:0]  r_off;

  logic        w_grant_d;
  logic        w_accept;
  logic [63:0] w_sel_addr;
  logic [1:0]  w_sel_size;
  logic        w_sel_we;
  logic        w_in_range;
  logic        w_misaligned;
  logic        w_err;
  logic [2:0]  w_off;
  logic [63:0] w_idx;
  logic [7:0]  w_lane_base;
  logic [7:0]  w_lanes;
  logic [63:0] w_wmask;
  logic [63:0] w_wdata_sh;
  logic [63:0] w_rshift;
  logic [63:0] w_size_mask;
  logic [63:0] w_load_data;
  logic [31:0] w_inst;

  assign dbg_state = r_state;

  // Handshake: a request transfers on a rising edge where valid && ready.
  // Ready is only offered in IDLE and only toward the granted side.
  always_comb begin
    w_grant_d    = d_req_valid && (!if_req_valid || !r_last_grant);
    if_req_ready = (r_state == S_IDLE) && if_req_valid && !w_grant_d;
    d_req_ready  = (r_state == S_IDLE) && w_grant_d;
    w_accept     = if_req_ready || d_req_ready;
    w_sel_addr   = w_grant_d ? d_req_addr : if_req_addr;
    w_sel_size   = w_grant_d ? d_req_size : 2'd2;
    w_sel_we     = w_grant_d && d_req_we;
    w_in_range   = (w_sel_addr >= BASE) && ((w_sel_addr - BASE) < RAM_BYTES);
    case (w_sel_size)
      2'd0:    w_misaligned = 1'b0;
      2'd1:    w_misaligned = w_sel_addr[0];
      2'd2:    w_misaligned = |w_sel_addr[1:0];
      default: w_misaligned = |w_sel_addr[2:0];
    endcase
    w_err = w_misaligned || !w_in_range;
    w_off = w_sel_addr[2:0];
    w_idx = (w_sel_addr - BASE) >> 3;
  end

  // Store lane generation from the incoming request.
  always_comb begin
    case (w_sel_size)
      2'd0:    w_lane_base = 8'h01;
      2'd1:    w_lane_base = 8'h03;
      2'd2:    w_lane_base = 8'h0F;
      default: w_lane_base = 8'hFF;
    endcase
    w_lanes = w_lane_base << w_off;
    w_wmask = 64'h0;
    for (int i = 0; i < 8; i++) begin
      w_wmask[i*8 +: 8] = {8{w_lanes[i]}};
    end
    w_wdata_sh = d_req_wdata << {w_off, 3'b000};
  end

  // Read-data extraction uses the latched offset/size of the in-flight request.
  always_comb begin
    w_rshift = ram_rdata >> {r_off, 3'b000};
    case (r_size)
      2'd0:    w_size_mask = 64'h0000_0000_0000_00FF;
      2'd1:    w_size_mask = 64'h0000_0000_0000_FFFF;
      2'd2:    w_size_mask = 64'h0000_0000_FFFF_FFFF;
      default: w_size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    w_load_data = w_rshift & w_size_mask;
    w_inst      = r_off[2] ? ram_rdata[63:32] : ram_rdata[31:0];
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_err ? S_RESP : S_ISSUE;
      S_ISSUE: w_next = r_we ? S_RESP : S_WAIT;
      S_WAIT:  w_next = S_RESP;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_last_grant  <= 1'b0;
      r_side        <= 1'b0;
      r_we          <= 1'b0;
      r_size        <= 2'd0;
      r_off         <= 3'd0;
      ram_ren       <= 1'b0;
      ram_ridx      <= 64'h0;
      ram_wen       <= 1'b0;
      ram_widx      <= 64'h0;
      ram_wdata     <= 64'h0;
      ram_wmask     <= 64'h0;
      if_resp_valid <= 1'b0;
      if_resp_inst  <= 32'h0;
      if_resp_err   <= 1'b0;
      d_resp_valid  <= 1'b0;
      d_resp_rdata  <= 64'h0;
      d_resp_err    <= 1'b0;
    end else begin
      r_state       <= w_next;
      // Strobes and pulses are single-cycle; response data/err are held.
      ram_ren       <= 1'b0;
      ram_ridx      <= 64'h0;
      ram_wen       <= 1'b0;
      ram_widx      <= 64'h0;
      ram_wdata     <= 64'h0;
      ram_wmask     <= 64'h0;
      if_resp_valid <= 1'b0;
      d_resp_valid  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_side       <= w_grant_d;
            r_last_grant <= w_grant_d;
            r_we         <= w_sel_we;
            r_size       <= w_sel_size;
            r_off        <= w_off;
            if (w_err) begin
              if (w_grant_d) begin
                d_resp_valid <= 1'b1;
                d_resp_rdata <= 64'h0;
                d_resp_err   <= 1'b1;
              end else begin
                if_resp_valid <= 1'b1;
                if_resp_inst  <= 32'h0;
                if_resp_err   <= 1'b1;
              end
            end else if (w_sel_we) begin
              ram_wen   <= 1'b1;
              ram_widx  <= w_idx;
              ram_wdata <= w_wdata_sh;
              ram_wmask <= w_wmask;
            end else begin
              ram_ren  <= 1'b1;
              ram_ridx <= w_idx;
            end
          end
        end
        S_ISSUE: begin
          if (r_we) begin
            d_resp_valid <= 1'b1;
            d_resp_rdata <= 64'h0;
            d_resp_err   <= 1'b0;
          end
        end
        S_WAIT: begin
          if (r_side) begin
            d_resp_valid <= 1'b1;
            d_resp_rdata <= w_load_data;
            d_resp_err   <= 1'b0;
          end else begin
            if_resp_valid <= 1'b1;
            if_resp_inst  <= w_inst;
            if_resp_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge: fetch, store, loads, arbitration, errors and
// reset during an in-flight load, against a small word-addressed RAM model.
module tb_mem_bridge;

  logic        clock;
  logic        reset_n;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [63:0] if_req_addr;
  logic        if_resp_valid;
  logic [31:0] if_resp_inst;
  logic        if_resp_err;
  logic        d_req_valid;
  logic        d_req_ready;
  logic        d_req_we;
  logic [63:0] d_req_addr;
  logic [1:0]  d_req_size;
  logic [63:0] d_req_wdata;
  logic        d_resp_valid;
  logic [63:0] d_resp_rdata;
  logic        d_resp_err;
  logic        ram_ren;
  logic [63:0] ram_ridx;
  logic [63:0] ram_rdata;
  logic        ram_wen;
  logic [63:0] ram_widx;
  logic [63:0] ram_wdata;
  logic [63:0] ram_wmask;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_err    = 0;

  logic [63:0] mem [0:15] = '{0: 64'h1122_3344_5566_7788,
                              1: 64'h0123_4567_89AB_A5F0,
                              default: 64'h0};

  mem_bridge dut (
    .clock(clock), .reset_n(reset_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_resp_valid(if_resp_valid), .if_resp_inst(if_resp_inst), .if_resp_err(if_resp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
    .d_req_addr(d_req_addr), .d_req_size(d_req_size), .d_req_wdata(d_req_wdata),
    .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata), .d_resp_err(d_resp_err),
    .ram_ren(ram_ren), .ram_ridx(ram_ridx), .ram_rdata(ram_rdata),
    .ram_wen(ram_wen), .ram_widx(ram_widx), .ram_wdata(ram_wdata), .ram_wmask(ram_wmask),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM model: read data valid the cycle after ram_ren, masked writes.
  always @(posedge clock) begin
    if (ram_ren) ram_rdata <= mem[ram_ridx[3:0]];
    if (ram_wen) mem[ram_widx[3:0]] <= (mem[ram_widx[3:0]] & ~ram_wmask) | (ram_wdata & ram_wmask);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(negedge clock);
  endtask

  // Driver: waits (bounded) for ready, lets the handshake edge pass, and
  // returns at the negedge of cycle T+1 with the request dropped.
  task automatic wait_hs(input logic side);
    int n;
    n = 0;
    #1;
    while (!(side ? d_req_ready : if_req_ready) && n < 20) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk("hs_timeout", 64'(n < 20), 64'd1);
    @(posedge clock);
    @(negedge clock);
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
  endtask

  task automatic req_fetch(input logic [63:0] a);
    if_req_addr  = a;
    if_req_valid = 1'b1;
    wait_hs(1'b0);
  endtask

  task automatic req_data(input logic we, input logic [1:0] sz, input logic [63:0] a,
                          input logic [63:0] wd);
    d_req_we    = we;
    d_req_size  = sz;
    d_req_addr  = a;
    d_req_wdata = wd;
    d_req_valid = 1'b1;
    wait_hs(1'b1);
  endtask

  // Read load through T+3 and check the data response and pulse width.
  task automatic load_check(input string tag, input logic [1:0] sz, input logic [63:0] a,
                            input logic [63:0] exp);
    req_data(1'b0, sz, a, 64'h0);
    nxt;
    nxt;
    chk({tag, "_valid"}, 64'(d_resp_valid), 64'd1);
    chk({tag, "_data"}, d_resp_rdata, exp);
    chk({tag, "_err"}, 64'(d_resp_err), 64'd0);
    nxt;
    chk({tag, "_pulse_end"}, 64'(d_resp_valid), 64'd0);
  endtask

  int grant_side [4];
  int grant_cyc  [4];
  int ng;

  initial begin
    reset_n = 1'b0;
    if_req_valid = 1'b0; if_req_addr = 64'h0;
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = 64'h0;
    d_req_size = 2'd0; d_req_wdata = 64'h0;
    #1;
    chk("rst_if_ready", 64'(if_req_ready), 64'd0);
    chk("rst_d_ready", 64'(d_req_ready), 64'd0);
    chk("rst_ram_ren", 64'(ram_ren), 64'd0);
    chk("rst_ram_wen", 64'(ram_wen), 64'd0);
    chk("rst_d_rdata", d_resp_rdata, 64'h0);
    chk("rst_if_valid", 64'(if_resp_valid), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    nxt; nxt;
    reset_n = 1'b1;
    nxt;

    // Fetch of upper half of word 0
    req_fetch(64'h8000_0004);
    chk("f_ren_t1", 64'(ram_ren), 64'd1);
    chk("f_ridx_t1", ram_ridx, 64'd0);
    nxt;
    chk("f_ren_t2", 64'(ram_ren), 64'd0);
    chk("f_valid_t2", 64'(if_resp_valid), 64'd0);
    nxt;
    chk("f_valid_t3", 64'(if_resp_valid), 64'd1);
    chk("f_inst_t3", 64'(if_resp_inst), 64'h1122_3344);
    chk("f_err_t3", 64'(if_resp_err), 64'd0);
    nxt;
    chk("f_valid_t4", 64'(if_resp_valid), 64'd0);

    // Halfword store
    req_data(1'b1, 2'd1, 64'h8000_000A, 64'hBEEF);
    chk("sh_wen", 64'(ram_wen), 64'd1);
    chk("sh_ren", 64'(ram_ren), 64'd0);
    chk("sh_widx", ram_widx, 64'd1);
    chk("sh_wmask", ram_wmask, 64'h0000_0000_FFFF_0000);
    chk("sh_wdata", ram_wdata, 64'h0000_0000_BEEF_0000);
    nxt;
    chk("sh_wen_off", 64'(ram_wen), 64'd0);
    chk("sh_valid", 64'(d_resp_valid), 64'd1);
    chk("sh_rdata", d_resp_rdata, 64'h0);
    chk("sh_err", 64'(d_resp_err), 64'd0);
    nxt;
    chk("sh_pulse_end", 64'(d_resp_valid), 64'd0);

    // Loads of several sizes
    load_check("lb", 2'd0, 64'h8000_0009, 64'hA5);
    load_check("lh", 2'd1, 64'h8000_000A, 64'hBEEF);
    load_check("lw", 2'd2, 64'h8000_0000, 64'h5566_7788);
    load_check("ld", 2'd3, 64'h8000_0008, 64'h0123_4567_BEEF_A5F0);

    // Misaligned LW and out-of-range fetch
    req_data(1'b0, 2'd2, 64'h8000_0002, 64'h0);
    chk("mis_valid", 64'(d_resp_valid), 64'd1);
    chk("mis_err", 64'(d_resp_err), 64'd1);
    chk("mis_rdata", d_resp_rdata, 64'h0);
    chk("mis_ren", 64'(ram_ren), 64'd0);
    chk("mis_wen", 64'(ram_wen), 64'd0);
    nxt;
    chk("mis_idle", 64'(dbg_state), 64'd0);
    chk("mis_pulse_end", 64'(d_resp_valid), 64'd0);
    req_fetch(64'h7FFF_FFFC);
    chk("oor_valid", 64'(if_resp_valid), 64'd1);
    chk("oor_err", 64'(if_resp_err), 64'd1);
    chk("oor_inst", 64'(if_resp_inst), 64'h0);
    chk("oor_ren", 64'(ram_ren), 64'd0);
    chk("oor_wen", 64'(ram_wen), 64'd0);
    nxt;
    chk("oor_idle", 64'(dbg_state), 64'd0);

    // Reset during WAIT of a load
    req_data(1'b0, 2'd3, 64'h8000_0008, 64'h0);
    nxt;
    chk("rw_in_wait", 64'(dbg_state), 64'd2);
    reset_n = 1'b0;
    #1;
    chk("rw_state", 64'(dbg_state), 64'd0);
    chk("rw_ren", 64'(ram_ren), 64'd0);
    chk("rw_d_rdata", d_resp_rdata, 64'h0);
    chk("rw_if_err", 64'(if_resp_err), 64'd0);
    nxt;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("rw_no_resp", 64'(d_resp_valid), 64'd0);
      nxt;
    end
    req_data(1'b0, 2'd3, 64'h8000_0008, 64'h0);
    chk("rw_re_ren", 64'(ram_ren), 64'd1);
    chk("rw_re_ridx", ram_ridx, 64'd1);
    nxt;
    chk("rw_re_t2", 64'(d_resp_valid), 64'd0);
    nxt;
    chk("rw_re_valid", 64'(d_resp_valid), 64'd1);
    chk("rw_re_data", d_resp_rdata, 64'h0123_4567_BEEF_A5F0);
    nxt;

    // Arbitration from fresh reset: both valid continuously
    reset_n = 1'b0;
    nxt;
    reset_n = 1'b1;
    if_req_addr = 64'h8000_0000;
    d_req_we = 1'b0; d_req_size = 2'd3; d_req_addr = 64'h8000_0008;
    if_req_valid = 1'b1;
    d_req_valid  = 1'b1;
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      #1;
      chk("arb_one_ready", 64'(if_req_ready && d_req_ready), 64'd0);
      if (d_req_ready) begin
        grant_side[ng] = 1; grant_cyc[ng] = c; ng++;
      end else if (if_req_ready) begin
        grant_side[ng] = 0; grant_cyc[ng] = c; ng++;
      end
      nxt;
    end
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
    chk("arb_count", 64'(ng), 64'd4);
    if (ng == 4) begin
      chk("arb_g0", 64'(grant_side[0]), 64'd1);
      chk("arb_g1", 64'(grant_side[1]), 64'd0);
      chk("arb_g2", 64'(grant_side[2]), 64'd1);
      chk("arb_g3", 64'(grant_side[3]), 64'd0);
      for (int i = 1; i < 4; i++) begin
        chk("arb_spacing", 64'(grant_cyc[i] - grant_cyc[i-1]), 64'd4);
      end
    end
    for (int i = 0; i < 6; i++) nxt;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_bridge.md
# mem_bridge

Single-port memory bridge between the core's instruction-fetch and load/store ports and the difftest `RAMHelper`. It replaces the combinational fetch/data address mux in the simulation top level. It arbitrates the two requesters and sequences one RAM transaction at a time. It also generates byte masks and lane shifts, and flags misaligned or out-of-range accesses without touching RAM.

## Interface
Parameters:
- `BASE`, 64'h8000_0000, byte address of RAM word 0.
- `RAM_BYTES`, 64'h0800_0000, RAM size; valid range is `BASE <= addr < BASE+RAM_BYTES`.

Ports:
- `clock` in 1, the single clock.
- `reset_n` in 1, asynchronous, active-low.
- `if_req_valid` in 1; `if_req_ready` out 1; `if_req_addr` in 64, fetch request handshake.
- `if_resp_valid` out 1, one-cycle pulse; `if_resp_inst` out 32; `if_resp_err` out 1.
- `d_req_valid` in 1; `d_req_ready` out 1; `d_req_we` in 1; `d_req_addr` in 64.
- `d_req_size` in 2, encoded 0=B, 1=H, 2=W, 3=D.
- `d_req_wdata` in 64, store data, LSB-aligned.
- `d_resp_valid` out 1, one-cycle pulse; `d_resp_rdata` out 64; `d_resp_err` out 1.
- `ram_ren` out 1; `ram_ridx` out 64; `ram_rdata` in 64, valid the cycle after `ram_ren`.
- `ram_wen` out 1; `ram_widx` out 64; `ram_wdata` out 64; `ram_wmask` out 64.

## Operation
- FSM states:
  - IDLE: `if_req_ready`/`d_req_ready` may be high only in this state.
  - ISSUE: drives the RAM strobe.
  - WAIT: captures `ram_rdata`.
  - RESP: raises the response pulse.
- Grant rules in IDLE:
  - Only one requester valid: that one is granted.
  - Both valid: grant goes to the side not granted last. The `last_grant` register resets to fetch, so the first tie goes to data.
  - Exactly one ready is asserted, and only toward the granted side.
  - The request (addr, size, we, wdata, side) is latched on the handshake.
- Error check at accept:
  - fetch: `addr[1:0] != 0`.
  - data: `addr mod (1<<size) != 0`.
  - either: address out of range.
  - On error: IDLE to RESP directly, with err=1, data=0, and no RAM strobe.
- Read (fetch, or load with we=0):
  - Sequence is IDLE, ISSUE (`ram_ren`=1), WAIT (latch `ram_rdata`), RESP, IDLE.
  - `ram_ridx = (addr-BASE)>>3`.
  - Fetch: `if_resp_inst = addr[2] ? rdata[63:32] : rdata[31:0]`.
  - Load: `d_resp_rdata = (rdata >> 8*addr[2:0])`, masked to `8<<size` bits and zero-extended. The core does sign extension.
- Store:
  - Sequence is IDLE, ISSUE (`ram_wen`=1), RESP, IDLE.
  - `ram_widx = (addr-BASE)>>3`.
  - `ram_wmask`: (`1<<size`) byte lanes of 8'hFF, starting at lane `addr[2:0]`.
  - `ram_wdata = wdata << 8*addr[2:0]`.
  - `d_resp_rdata` = 0.
- RESP lasts one cycle and always returns to IDLE. Responses are not back-pressured; the core must accept the pulse.
- All RAM outputs and response outputs are registered.
- RAM outputs are 0 whenever not in the strobing state. Response data and err are held until the next response.

## Timing
- Request handshake completes in cycle T.
- Read: strobe at T+1, `ram_rdata` sampled at the end of T+2, resp pulse at T+3, next accept no earlier than T+4.
- Store: `ram_wen` at T+1, resp at T+2, next accept at T+3.
- Error: resp at T+1, next accept at T+2.
- Reset values:
  - All outputs are 0, the FSM is in IDLE, and `last_grant` is fetch.
  - The ready outputs may rise combinationally in the first cycle after reset release.
- `reset_n` asserted mid-transaction: the FSM returns to IDLE immediately and strobes drop asynchronously. The in-flight response is discarded, and the requester must reissue.
- A requester dropping valid without a handshake has no effect. Valid held across a RESP cycle is granted in the following IDLE cycle.

## Test plan
- Fetch 0x8000_0004, with RAM word 0 = 64'h1122_3344_5566_7788 -> `ram_ren` at T+1, idx 0; `if_resp_valid` at T+3 with inst 32'h1122_3344, err 0.
- Store SH 0x8000_000A, wdata 0xBEEF -> at T+1 `ram_widx`=1, `ram_wmask`=64'h0000_0000_FFFF_0000, `ram_wdata`=64'h0000_0000_BEEF_0000; `d_resp_valid` at T+2.
- LB 0x8000_0009, with word 1 = 64'h...A5F0 -> `d_resp_rdata`=64'hA5, err 0.
- Both valid continuously for 4 grants -> grant order data, fetch, data, fetch; no back-to-back grant to one side while the other waits.
- LW 0x8000_0002 (misaligned), and fetch 0x7FFF_FFFC (out of range) -> err=1 at T+1, `ram_ren`/`ram_wen` never asserted.
- `reset_n` low during WAIT of a load -> outputs 0 immediately, no `d_resp_valid`; after release, a reissued load completes with the normal T+3 latency.
